// File: rtl/instr_fetch.sv
// instr_fetch: ROM-side fetch unit with a 2-entry prefetch queue, branch redirect and optional halt detection (HALT_DETECT_EN)
module instr_fetch #(
    parameter int         DEPTH   = 2,
    parameter logic [3:0] HALT_OP = 4'h7
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_q,
    output logic [15:0] instr,
    output logic [7:0]  instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_valid,
    input  logic [7:0]  branch_target,
    output logic        halted
);
`ifdef HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    logic        inflight;
    logic [7:0]  inflight_pc;
    logic [15:0] q_instr [2];
    logic [7:0]  q_pc [2];
    logic [1:0]  count;
    logic [1:0]  next_count;
    logic        push, pop, issue, halt_push, wr_idx;
    assign instr_valid = count != 2'd0;
    assign instr       = q_instr[0];
    assign instr_pc    = q_pc[0];
    // Credit check: issue only if the word it produces is guaranteed a free slot
    always_comb begin
        pop        = instr_valid & instr_ready;
        push       = inflight & ~branch_valid;
        next_count = count + {1'b0, push} - {1'b0, pop};
        issue      = ~branch_valid & ~halted & (int'(next_count) < DEPTH);
        halt_push  = HALT_EN & push & (rom_q[15:12] == HALT_OP);
        wr_idx     = count[1] | (count[0] & ~pop);
    end
    // Fetch address and in-flight tracking; the word behind a halt is discarded
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rom_addr    <= 8'h00;
            inflight    <= 1'b0;
            inflight_pc <= 8'h00;
        end else if (branch_valid) begin
            rom_addr <= branch_target;
            inflight <= 1'b0;
        end else begin
            inflight <= issue & ~halt_push;
            if (issue) begin
                inflight_pc <= rom_addr;
                rom_addr    <= rom_addr + 8'd1;
            end
        end
    end
    // Shift-style FIFO: head lives in slot 0, a push into slot 0 overrides the shift
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_instr <= '{default: '0};
            q_pc    <= '{default: '0};
            count   <= 2'd0;
        end else if (branch_valid) begin
            count <= 2'd0;
        end else begin
            if (pop) begin
                q_instr[0] <= q_instr[1];
                q_pc[0]    <= q_pc[1];
            end
            if (push) begin
                q_instr[wr_idx] <= rom_q;
                q_pc[wr_idx]    <= inflight_pc;
            end
            count <= next_count;
        end
    end
    // Halt flag is set by a queued halt word and cleared only by a redirect
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            halted <= 1'b0;
        else if (branch_valid)
            halted <= 1'b0;
        else if (halt_push)
            halted <= 1'b1;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of startup timing, backpressure, branch flush, halt, wrap-around and mid-stream reset
module tb_instr_fetch;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  rom_addr, instr_pc, branch_target;
    logic [15:0] rom_q, instr;
    logic        instr_valid, instr_ready, branch_valid, halted;
    logic [15:0] rom [256];
    logic [24:0] head;
    int          checks = 0;
    int          errors = 0;

    instr_fetch dut (
        .CLK(CLK), .RST_N(RST_N), .rom_addr(rom_addr), .rom_q(rom_q),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .branch_valid(branch_valid),
        .branch_target(branch_target), .halted(halted)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) rom_q <= rom[rom_addr];
    assign head = {instr_valid, instr, instr_pc};

`ifdef HALT_DETECT_EN
    localparam bit HALT_ON = 1'b1;
`else
    localparam bit HALT_ON = 1'b0;
`endif

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST_N = 1'b0; instr_ready = 1'b1; branch_valid = 1'b0; branch_target = 8'h00;
        tick;
        checks++; if (head !== 25'h0) begin errors++; $display("FAIL reset_head: got %h exp %h", head, 25'h0); end
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h exp 00", rom_addr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b exp 0", halted); end
        tick;
        RST_N = 1'b1;
    endtask

    task automatic test_startup;
        tick;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL e1_valid: got %b exp 0", instr_valid); end
        checks++; if (rom_addr !== 8'h01) begin errors++; $display("FAIL e1_addr: got %h exp 01", rom_addr); end
        tick;
        checks++; if (head !== {1'b1, 16'h8000, 8'h00}) begin errors++; $display("FAIL e2_head: got %h exp %h", head, {1'b1, 16'h8000, 8'h00}); end
        tick;
        checks++; if (head !== {1'b1, 16'hA07D, 8'h01}) begin errors++; $display("FAIL e3_head: got %h exp %h", head, {1'b1, 16'hA07D, 8'h01}); end
        tick;
        checks++; if (head !== {1'b1, 16'h8500, 8'h02}) begin errors++; $display("FAIL e4_head: got %h exp %h", head, {1'b1, 16'h8500, 8'h02}); end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp_pc;
        RST_N = 1'b0; instr_ready = 1'b0;
        tick; tick;
        RST_N = 1'b1;
        tick; tick;
        checks++; if (head !== {1'b1, 16'h8000, 8'h00}) begin errors++; $display("FAIL bp_first: got %h exp %h", head, {1'b1, 16'h8000, 8'h00}); end
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++; if (head !== {1'b1, 16'h8000, 8'h00}) begin errors++; $display("FAIL bp_hold_head: got %h exp %h", head, {1'b1, 16'h8000, 8'h00}); end
            checks++; if (rom_addr !== 8'h02) begin errors++; $display("FAIL bp_hold_addr: got %h exp 02", rom_addr); end
        end
        instr_ready = 1'b1;
        exp_pc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            checks++; if (head !== {1'b1, rom[exp_pc], exp_pc}) begin errors++; $display("FAIL bp_drain: got %h exp %h", head, {1'b1, rom[exp_pc], exp_pc}); end
            exp_pc++;
            tick;
        end
    endtask

    task automatic test_branch_flush;
        RST_N = 1'b0; instr_ready = 1'b0;
        tick; tick;
        RST_N = 1'b1;
        tick; tick; tick;
        checks++; if ({head, rom_addr} !== {1'b1, 16'h8000, 8'h00, 8'h02}) begin errors++; $display("FAIL br_prefill: got %h exp %h", {head, rom_addr}, {1'b1, 16'h8000, 8'h00, 8'h02}); end
        instr_ready = 1'b1; branch_valid = 1'b1; branch_target = 8'h06;
        tick;
        branch_valid = 1'b0;
        checks++; if ({instr_valid, rom_addr} !== {1'b0, 8'h06}) begin errors++; $display("FAIL br_b0: got %h exp %h", {instr_valid, rom_addr}, {1'b0, 8'h06}); end
        tick;
        checks++; if ({instr_valid, rom_addr} !== {1'b0, 8'h07}) begin errors++; $display("FAIL br_b1: got %h exp %h", {instr_valid, rom_addr}, {1'b0, 8'h07}); end
        tick;
        checks++; if (head !== {1'b1, 16'h8F00, 8'h06}) begin errors++; $display("FAIL br_b2: got %h exp %h", head, {1'b1, 16'h8F00, 8'h06}); end
        tick;
        checks++; if (head !== {1'b1, 16'hCE08, 8'h07}) begin errors++; $display("FAIL br_b3: got %h exp %h", head, {1'b1, 16'hCE08, 8'h07}); end
    endtask

    task automatic test_halt;
        tick;
        checks++; if (head !== {1'b1, 16'h7000, 8'h08}) begin errors++; $display("FAIL halt_word: got %h exp %h", head, {1'b1, 16'h7000, 8'h08}); end
        checks++; if ({halted, rom_addr} !== {HALT_ON, 8'h0A}) begin errors++; $display("FAIL halt_set: got %h exp %h", {halted, rom_addr}, {HALT_ON, 8'h0A}); end
        tick;
        if (HALT_ON) begin
            checks++; if ({instr_valid, halted, rom_addr} !== {2'b01, 8'h0A}) begin errors++; $display("FAIL halt_idle1: got %h exp %h", {instr_valid, halted, rom_addr}, {2'b01, 8'h0A}); end
        end else begin
            checks++; if ({head, halted} !== {1'b1, 16'h1111, 8'h09, 1'b0}) begin errors++; $display("FAIL nohalt_pc9: got %h exp %h", {head, halted}, {1'b1, 16'h1111, 8'h09, 1'b0}); end
        end
        tick;
        if (HALT_ON) begin
            checks++; if ({instr_valid, halted, rom_addr} !== {2'b01, 8'h0A}) begin errors++; $display("FAIL halt_idle2: got %h exp %h", {instr_valid, halted, rom_addr}, {2'b01, 8'h0A}); end
        end else begin
            checks++; if ({head, rom_addr} !== {1'b1, 16'h2222, 8'h0A, 8'h0C}) begin errors++; $display("FAIL nohalt_pc10: got %h exp %h", {head, rom_addr}, {1'b1, 16'h2222, 8'h0A, 8'h0C}); end
        end
        branch_valid = 1'b1; branch_target = 8'h00;
        tick;
        branch_valid = 1'b0;
        checks++; if ({instr_valid, halted, rom_addr} !== {2'b00, 8'h00}) begin errors++; $display("FAIL restart_b0: got %h exp %h", {instr_valid, halted, rom_addr}, {2'b00, 8'h00}); end
        tick; tick;
        checks++; if ({head, halted} !== {1'b1, 16'h8000, 8'h00, 1'b0}) begin errors++; $display("FAIL restart_word: got %h exp %h", {head, halted}, {1'b1, 16'h8000, 8'h00, 1'b0}); end
    endtask

    task automatic test_wrap;
        branch_valid = 1'b1; branch_target = 8'hFF;
        tick;
        branch_valid = 1'b0;
        checks++; if (rom_addr !== 8'hFF) begin errors++; $display("FAIL wrap_b0: got %h exp ff", rom_addr); end
        tick;
        checks++; if ({instr_valid, rom_addr} !== {1'b0, 8'h00}) begin errors++; $display("FAIL wrap_b1: got %h exp %h", {instr_valid, rom_addr}, {1'b0, 8'h00}); end
        tick;
        checks++; if (head !== {1'b1, 16'hBEEF, 8'hFF}) begin errors++; $display("FAIL wrap_ff: got %h exp %h", head, {1'b1, 16'hBEEF, 8'hFF}); end
        tick;
        checks++; if (head !== {1'b1, 16'h8000, 8'h00}) begin errors++; $display("FAIL wrap_00: got %h exp %h", head, {1'b1, 16'h8000, 8'h00}); end
    endtask

    task automatic test_reset_mid;
        tick; tick;
        #3;
        RST_N = 1'b0;
        #1;
        checks++; if ({head, halted, rom_addr} !== 34'h0) begin errors++; $display("FAIL rstmid_async: got %h exp %h", {head, halted, rom_addr}, 34'h0); end
        tick;
        checks++; if ({head, halted, rom_addr} !== 34'h0) begin errors++; $display("FAIL rstmid_hold: got %h exp %h", {head, halted, rom_addr}, 34'h0); end
        RST_N = 1'b1;
        test_startup;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h8000; rom[1] = 16'hA07D; rom[2] = 16'h8500; rom[4] = 16'hA52D;
        rom[5] = 16'h3180; rom[6] = 16'h8F00; rom[7] = 16'hCE08; rom[8] = 16'h7000;
        rom[9] = 16'h1111; rom[10] = 16'h2222; rom[255] = 16'hBEEF;
        test_reset;
        test_startup;
        test_backpressure;
        test_branch_flush;
        test_halt;
        test_wrap;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
